// File: rtl/vend_sequencer.sv
// Vending-machine purchase sequencer: coin accumulation, item selection, dispense timing,
// change/refund calculation, with BCD views of the payment, price and change registers.
module vend_sequencer #(
    parameter int SERVO_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       clr_n,
    input  logic       coin_pulse,
    input  logic [3:0] coin_val,
    input  logic       sel_valid,
    input  logic [1:0] sel_code,
    input  logic       confirm,
    input  logic       cancel,
    output logic [2:0] state,
    output logic [7:0] paid_bcd,
    output logic [7:0] price_bcd,
    output logic [7:0] change_bcd,
    output logic       change_valid,
    output logic       servo_en,
    output logic [3:0] good,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SV_W = $clog2(SERVO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SV_W-1:0] SV_LAST = SV_W'(SERVO_CYCLES - 1);
    localparam logic [6:0] PAID_MAX = 7'd99;

    function automatic logic [6:0] price_of(input logic [1:0] code);
        case (code)
            2'd0:    return 7'd3;
            2'd1:    return 7'd5;
            2'd2:    return 7'd8;
            default: return 7'd10;
        endcase
    endfunction

    // Repeated subtraction of ten; inputs never exceed 99 so nine passes suffice.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'b0000} + {1'b0, rem};
    endfunction

    state_t          state_q, state_d;
    logic [6:0]      paid_q, paid_d;
    logic [6:0]      price_q, price_d;
    logic [1:0]      item_q, item_d;
    logic [6:0]      change_q, change_d;
    logic            change_valid_q, change_valid_d;
    logic            servo_q, servo_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [SV_W-1:0] sv_cnt_q, sv_cnt_d;
    logic [7:0]      coin_sum;
    logic            coin_open;

    assign coin_sum  = {1'b0, paid_q} + {4'b0000, coin_val};
    assign coin_open = (state_q == ST_IDLE) || (state_q == ST_SELECT);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d        = state_q;
        paid_d         = paid_q;
        price_d        = price_q;
        item_d         = item_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        servo_d        = servo_q;
        err_d          = 1'b0;
        to_cnt_d       = to_cnt_q;
        sv_cnt_d       = sv_cnt_q;

        if (coin_pulse) begin
            if (!coin_open) begin
                err_d = 1'b1;
            end else if (coin_sum > {1'b0, PAID_MAX}) begin
                paid_d = PAID_MAX;
                err_d  = 1'b1;
            end else begin
                paid_d = coin_sum[6:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    price_d  = price_of(sel_code);
                    item_d   = sel_code;
                    to_cnt_d = '0;
                    state_d  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // A coin or new selection in the same cycle swallows a confirm silently.
                if (cancel) begin
                    state_d = ST_REFUND;
                end else if (coin_pulse || sel_valid) begin
                    to_cnt_d = '0;
                    if (sel_valid) begin
                        price_d = price_of(sel_code);
                        item_d  = sel_code;
                    end
                end else if (confirm) begin
                    to_cnt_d = '0;
                    if (paid_q >= price_q) begin
                        sv_cnt_d = '0;
                        state_d  = ST_DISPENSE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_REFUND;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_DISPENSE: begin
                if (!servo_q) begin
                    servo_d  = 1'b1;
                    sv_cnt_d = '0;
                end else if (sv_cnt_q == SV_LAST) begin
                    servo_d = 1'b0;
                    state_d = ST_CHANGE;
                end else begin
                    sv_cnt_d = sv_cnt_q + SV_W'(1);
                end
            end
            ST_CHANGE: begin
                change_d       = paid_q - price_q;
                change_valid_d = 1'b1;
                paid_d         = '0;
                price_d        = '0;
                state_d        = ST_IDLE;
            end
            ST_REFUND: begin
                change_d       = paid_q;
                change_valid_d = 1'b1;
                paid_d         = '0;
                price_d        = '0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= ST_IDLE;
            paid_q         <= '0;
            price_q        <= '0;
            item_q         <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            servo_q        <= 1'b0;
            err_q          <= 1'b0;
            to_cnt_q       <= '0;
            sv_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            paid_q         <= paid_d;
            price_q        <= price_d;
            item_q         <= item_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            servo_q        <= servo_d;
            err_q          <= err_d;
            to_cnt_q       <= to_cnt_d;
            sv_cnt_q       <= sv_cnt_d;
        end
    end

    assign state        = state_q;
    assign paid_bcd     = to_bcd(paid_q);
    assign price_bcd    = to_bcd(price_q);
    assign change_bcd   = to_bcd(change_q);
    assign change_valid = change_valid_q;
    assign servo_en     = servo_q;
    assign good         = servo_q ? (4'b0001 << item_q) : 4'b0000;
    assign err          = err_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed purchase scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model of the machine.
module tb_vend_sequencer;

    localparam int SERVO   = 50;
    localparam int TIMEOUT = 1000;

    logic       clock = 1'b0;
    logic       clr_n = 1'b0;
    logic       coin_pulse = 1'b0;
    logic [3:0] coin_val = 4'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_code = 2'd0;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic [2:0] state;
    logic [7:0] paid_bcd, price_bcd, change_bcd;
    logic       change_valid, servo_en, err;
    logic [3:0] good;

    vend_sequencer dut (
        .clock(clock), .clr_n(clr_n), .coin_pulse(coin_pulse), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_code(sel_code), .confirm(confirm), .cancel(cancel),
        .state(state), .paid_bcd(paid_bcd), .price_bcd(price_bcd), .change_bcd(change_bcd),
        .change_valid(change_valid), .servo_en(servo_en), .good(good), .err(err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 choosing, 2 dispensing, 3 paying change, 4 refunding.
    int m_mode, m_paid, m_price, m_item, m_change, m_quiet, m_disp_t;
    bit m_cv, m_err;

    function automatic int price_tab(input int code);
        int tab[4] = '{3, 5, 8, 10};
        return tab[code];
    endfunction

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_paid = 0; m_price = 0; m_item = 0; m_change = 0;
        m_quiet = 0; m_disp_t = 0; m_cv = 0; m_err = 0;
    endtask

    task automatic model_step();
        int p0;
        p0 = m_paid;
        m_cv = 0;
        m_err = 0;
        if (coin_pulse) begin
            if (m_mode <= 1) begin
                if (p0 + int'(coin_val) > 99) begin
                    m_paid = 99;
                    m_err = 1;
                end else begin
                    m_paid = p0 + int'(coin_val);
                end
            end else begin
                m_err = 1;
            end
        end
        case (m_mode)
            0: if (sel_valid) begin
                m_price = price_tab(int'(sel_code));
                m_item = int'(sel_code);
                m_quiet = 0;
                m_mode = 1;
            end
            1: begin
                if (cancel) m_mode = 4;
                else if (coin_pulse || sel_valid) begin
                    m_quiet = 0;
                    if (sel_valid) begin
                        m_price = price_tab(int'(sel_code));
                        m_item = int'(sel_code);
                    end
                end else if (confirm) begin
                    m_quiet = 0;
                    if (p0 >= m_price) begin
                        m_mode = 2;
                        m_disp_t = 0;
                    end else m_err = 1;
                end else begin
                    m_quiet++;
                    if (m_quiet == TIMEOUT) m_mode = 4;
                end
            end
            2: begin
                m_disp_t++;
                if (m_disp_t == SERVO + 1) m_mode = 3;
            end
            3: begin
                m_change = p0 - m_price;
                m_cv = 1; m_paid = 0; m_price = 0; m_mode = 0;
            end
            default: begin
                m_change = p0;
                m_cv = 1; m_paid = 0; m_price = 0; m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        bit srv;
        srv = (m_mode == 2) && (m_disp_t >= 1);
        check("state", 32'(state), 32'(m_mode));
        check("paid_bcd", 32'(paid_bcd), 32'(bcd(m_paid)));
        check("price_bcd", 32'(price_bcd), 32'(bcd(m_price)));
        check("change_bcd", 32'(change_bcd), 32'(bcd(m_change)));
        check("change_valid", 32'(change_valid), 32'(m_cv));
        check("servo_en", 32'(servo_en), 32'(srv));
        check("good", 32'(good), srv ? 32'(1 << m_item) : 32'd0);
        check("err", 32'(err), 32'(m_err));
    endtask

    int servo_seen, cv_seen, err_seen;
    logic [3:0] good_seen;

    task automatic clear_tally();
        servo_seen = 0; cv_seen = 0; err_seen = 0; good_seen = 4'd0;
    endtask

    // One clock: model advances with the DUT edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
        if (servo_en) servo_seen++;
        if (change_valid) cv_seen++;
        if (err) err_seen++;
        good_seen = good_seen | good;
        coin_pulse = 1'b0; sel_valid = 1'b0; confirm = 1'b0; cancel = 1'b0;
    endtask

    task automatic coin(input int v);
        coin_pulse = 1'b1; coin_val = 4'(v); cycle();
    endtask

    task automatic select(input int c);
        sel_valid = 1'b1; sel_code = 2'(c); cycle();
    endtask

    task automatic do_confirm();
        confirm = 1'b1; cycle();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(state) != target && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        model_reset();
        clear_tally();
        repeat (2) @(negedge clock);
        compare_all();
        check("reset_state", 32'(state), 32'd0);
        clr_n = 1'b1;

        // Basic purchase with change.
        coin(5); coin(5); select(2);
        clear_tally();
        do_confirm();
        check("buy_enter_dispense", 32'(state), 32'd2);
        run_until(0, 200, "buy_back_idle");
        check("buy_servo_cycles", 32'(servo_seen), 32'(SERVO));
        check("buy_good", 32'(good_seen), 32'b0100);
        check("buy_change", 32'(change_bcd), 32'h02);
        check("buy_cv_pulses", 32'(cv_seen), 32'd1);
        check("buy_paid_clear", 32'(paid_bcd), 32'h00);

        // Insufficient funds, coin swallowing confirm, then exact purchase.
        select(3); coin(5);
        do_confirm();
        check("short_err", 32'(err), 32'd1);
        check("short_state", 32'(state), 32'd1);
        coin_pulse = 1'b1; coin_val = 4'd5; confirm = 1'b1; cycle();
        check("coinconf_paid", 32'(paid_bcd), 32'h10);
        check("coinconf_err", 32'(err), 32'd0);
        check("coinconf_state", 32'(state), 32'd1);
        do_confirm();
        check("exact_dispense", 32'(state), 32'd2);
        run_until(0, 200, "exact_idle");
        check("exact_change", 32'(change_bcd), 32'h00);

        // Cancel refund.
        select(0); coin(1); coin(1);
        clear_tally();
        cancel = 1'b1; cycle();
        check("cancel_refund", 32'(state), 32'd4);
        cycle();
        check("cancel_idle", 32'(state), 32'd0);
        check("cancel_change", 32'(change_bcd), 32'h02);
        check("cancel_cv_pulses", 32'(cv_seen), 32'd1);

        // Timeout refund after exactly TIMEOUT quiet cycles.
        select(1);
        n = 0;
        while (int'(state) != 4 && n < TIMEOUT + 100) begin
            cycle();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        cycle();
        check("timeout_change", 32'(change_bcd), 32'h00);

        // Coin during dispense is rejected.
        select(0); coin(5); do_confirm();
        repeat (3) cycle();
        coin(5);
        check("disp_coin_err", 32'(err), 32'd1);
        check("disp_coin_paid", 32'(paid_bcd), 32'h05);
        run_until(0, 200, "disp_coin_idle");
        check("disp_coin_change", 32'(change_bcd), 32'h02);

        // Saturation at 99.
        clear_tally();
        for (int i = 0; i < 20; i++) coin(5);
        check("sat_paid", 32'(paid_bcd), 32'h99);
        check("sat_err_last", 32'(err), 32'd1);
        check("sat_err_count", 32'(err_seen), 32'd1);

        // Reset in the middle of dispense.
        select(3); do_confirm();
        repeat (10) cycle();
        check("pre_reset_servo", 32'(servo_en), 32'd1);
        #2 clr_n = 1'b0;
        #1;
        check("rst_servo", 32'(servo_en), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outputs", {paid_bcd, price_bcd, change_bcd, 3'b0, change_valid, good, err},
              32'd0);
        model_reset();
        @(negedge clock);
        clr_n = 1'b1;
        clear_tally();
        repeat (5) cycle();
        check("rst_no_cv", 32'(cv_seen), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            coin_pulse = ($urandom_range(0, 4) == 0);
            coin_val   = 4'($urandom_range(1, 9));
            sel_valid  = ($urandom_range(0, 9) == 0);
            sel_code   = 2'($urandom_range(0, 3));
            confirm    = ($urandom_range(0, 5) == 0);
            cancel     = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
